// File: rtl/rob_drain.sv
// rob_drain -- in-order drain of an 8-entry reorder buffer toward one channel.
//
// Tracks which ROB entries hold written data, reads them back strictly in
// head order, parks the returned data in a 2-entry output FIFO and hands the
// responses to the channel with a valid/ready handshake. A handed-over entry
// is reported as retired so the allocator can reuse it.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          synchronous reset, active low
//   wr_en_i        an entry was written into the ROB data buffer this cycle
//   wr_ptr_i       index of that entry
//   rd_en_o        read request to the ROB data buffer
//   rd_ptr_o       index to read
//   rd_data_i      read data, one cycle after rd_en_o
//   out_valid_o    response valid toward the channel
//   out_ready_i    channel accepts the response
//   out_rob_num_o  ROB index of the presented response
//   out_data_o     response data
//   retire_o       entry handed to the channel this cycle
//   retire_ptr_o   index retired
//   err_dup_o      sticky: an already-valid entry was written again
module rob_drain #(
  parameter int DATA_W     = 128,
  parameter int CHANNEL_ID = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_ptr_i,
  output logic              rd_en_o,
  output logic [2:0]        rd_ptr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [2:0]        out_rob_num_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              retire_o,
  output logic [2:0]        retire_ptr_o,
  output logic              err_dup_o
);

  logic [7:0]        valid_q, valid_d;
  logic [2:0]        head_q, head_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic [2:0]        rob0_q, rob0_d, rob1_q, rob1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              err_q, err_d;

  logic              issue_s;
  logic              pop_s;
  logic [1:0]        cap_pos_s;
  logic [7:0]        clr_mask_s;
  logic [7:0]        set_mask_s;

  // Credits are taken from registered state only, so a pop frees a slot for
  // issue one cycle later and FIFO occupancy plus the in-flight read never
  // exceeds two.
  assign issue_s = valid_q[head_q] &&
                   (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);
  assign pop_s   = (count_q != 2'd0) && out_ready_i;

  // Slot that the returning read lands in, after this cycle's pop.
  assign cap_pos_s = count_q - {1'b0, pop_s};

  // A write sets its bit after the issue clears head, so a write colliding
  // with the entry being issued leaves the bit set.
  assign clr_mask_s = issue_s ? (8'd1 << head_q) : 8'd0;
  assign set_mask_s = wr_en_i ? (8'd1 << wr_ptr_i) : 8'd0;

  // Next-state: valid bitmap, head, in-flight flag and duplicate-write error.
  always_comb begin
    valid_d    = (valid_q & ~clr_mask_s) | set_mask_s;
    head_d     = issue_s ? head_q + 3'd1 : head_q;
    inflight_d = issue_s;
    err_d      = err_q | (wr_en_i & valid_q[wr_ptr_i]);
  end

  // Next-state: 2-entry output FIFO; slot 0 is always the presented entry.
  always_comb begin
    count_d = count_q - {1'b0, pop_s} + {1'b0, inflight_q};
    rob0_d  = pop_s ? rob1_q : rob0_q;
    data0_d = pop_s ? data1_q : data0_q;
    rob1_d  = rob1_q;
    data1_d = data1_q;
    if (inflight_q) begin
      case (cap_pos_s)
        2'd0: begin
          rob0_d  = head_q - 3'd1;
          data0_d = rd_data_i;
        end
        2'd1: begin
          rob1_d  = head_q - 3'd1;
          data1_d = rd_data_i;
        end
        default: begin
          rob1_d  = rob1_q;
          data1_d = data1_q;
        end
      endcase
    end else begin
      rob1_d  = rob1_q;
      data1_d = data1_q;
    end
  end

  // State registers; reset drops in-flight reads and FIFO contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q    <= 8'd0;
      head_q     <= 3'd0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rob0_q     <= 3'd0;
      rob1_q     <= 3'd0;
      data0_q    <= '0;
      data1_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      head_q     <= head_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rob0_q     <= rob0_d;
      rob1_q     <= rob1_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      err_q      <= err_d;
    end
  end

  // The in-flight read's index is head-1: head advanced on the issue edge and
  // cannot move again while the read is outstanding... except by a second
  // issue in the same cycle, which the capture above already accounts for by
  // using the head value before this cycle's increment.
  assign rd_en_o       = issue_s;
  assign rd_ptr_o      = head_q;
  assign out_valid_o   = (count_q != 2'd0);
  assign out_rob_num_o = rob0_q;
  assign out_data_o    = data0_q;
  assign retire_o      = pop_s;
  assign retire_ptr_o  = rob0_q;
  assign err_dup_o     = err_q;

endmodule
